// File: rtl/credit_arbiter_if.sv
// Bundles the requester side and the output-queue side of credit_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives requests and sinks the output queue traffic.
interface credit_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int PACKET_WIDTH = 128,
  parameter int CREDITS      = 8
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            enq_valid;
  logic [PACKET_WIDTH-1:0]         enq_data;
  logic                            enq_ready;
  logic                            credit_return;
  logic [CNT_W-1:0]                credit_count;
  logic [ID_W-1:0]                 grant_id;
  logic                            credit_overflow;

  modport slave (
    input  req_valid, req_data, enq_ready, credit_return,
    output req_ready, enq_valid, enq_data, credit_count, grant_id, credit_overflow
  );

  modport master (
    output req_valid, req_data, enq_ready, credit_return,
    input  req_ready, enq_valid, enq_data, credit_count, grant_id, credit_overflow
  );
endinterface

// File: rtl/credit_arbiter.sv
// Round-robin arbiter feeding one output queue through a single registered
// stage. A credit counter mirrors the free slots downstream so no grant is
// ever issued that the queue could not absorb.
module credit_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PACKET_WIDTH = 128,
  parameter int CREDITS      = 8
) (
  input  logic             clk,
  input  logic             rst,
  credit_arbiter_if.slave  bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);
  localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]    NUM_REQ_W   = (ID_W + 1)'(NUM_REQ);

  // Registered state
  logic                    enq_valid_q, enq_valid_d;
  logic [PACKET_WIDTH-1:0] enq_data_q,  enq_data_d;
  logic [ID_W-1:0]         grant_id_q,  grant_id_d;
  logic [ID_W-1:0]         rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]        credit_q,    credit_d;
  logic                    overflow_q,  overflow_d;

  // Arbitration signals
  logic               found;
  logic [ID_W-1:0]    win;
  logic               can_load;
  logic               can_grant;
  logic               grant_fire;
  logic [NUM_REQ-1:0] grant_vec;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin : rr_search
    logic [ID_W:0] sum;
    // NOTE: every variable written here gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      if (!found && bus.req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
  end

  // Grant only when the output slot is free, credits remain and not in reset.
  always_comb begin
    can_load   = ~enq_valid_q | bus.enq_ready;
    can_grant  = can_load & (credit_q != '0) & ~rst;
    grant_fire = can_grant & found;
    grant_vec  = '0;
    if (grant_fire) grant_vec[win] = 1'b1;
  end

  // Next state for the output stage, round-robin pointer and credits.
  always_comb begin
    enq_valid_d = enq_valid_q;
    enq_data_d  = enq_data_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    overflow_d  = overflow_q;

    if (grant_fire) begin
      enq_valid_d = 1'b1;
      enq_data_d  = bus.req_data[win*PACKET_WIDTH +: PACKET_WIDTH];
      grant_id_d  = win;
      rr_ptr_d    = (win == LAST_ID) ? '0 : win + 1'b1;
    end else if (enq_valid_q && bus.enq_ready) begin
      enq_valid_d = 1'b0;
    end

    // A grant and a return in the same cycle cancel out.
    unique case ({grant_fire, bus.credit_return})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CREDITS_MAX) overflow_d = 1'b1;
        else                         credit_d   = credit_q + 1'b1;
      end
      default: ;
    endcase
  end

  // State registers with asynchronous reset; a reset drops any held packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_valid_q <= 1'b0;
      enq_data_q  <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      credit_q    <= CREDITS_MAX;
      overflow_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other, independent of statement order.
      enq_valid_q <= enq_valid_d;
      enq_data_q  <= enq_data_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.req_ready       = grant_vec;
  assign bus.enq_valid       = enq_valid_q;
  assign bus.enq_data        = enq_data_q;
  assign bus.grant_id        = grant_id_q;
  assign bus.credit_count    = credit_q;
  assign bus.credit_overflow = overflow_q;
endmodule

// File: tb/tb_credit_arbiter.sv
// Directed bench for credit_arbiter: reset, rotation, credit exhaustion,
// grant/return collision, backpressure, overflow and mid-traffic reset.
module tb_credit_arbiter;
  localparam int NR = 4;
  localparam int PW = 128;
  localparam int CR = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   accepts;
  logic [PW-1:0] lane_data [NR];

  credit_arbiter_if #(.NUM_REQ(NR), .PACKET_WIDTH(PW), .CREDITS(CR)) bus ();

  credit_arbiter #(.NUM_REQ(NR), .PACKET_WIDTH(PW), .CREDITS(CR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [PW-1:0] pkt(input int i);
    return PW'(128'hC0DE_0000 + 128'(i));
  endfunction

  task automatic load_lanes();
    for (int i = 0; i < NR; i++) bus.req_data[i*PW +: PW] = lane_data[i];
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) lane_data[i] = pkt(i);
    rst               = 1'b1;
    bus.req_valid     = 4'hF;
    bus.enq_ready     = 1'b1;
    bus.credit_return = 1'b0;
    load_lanes();

    // Reset state
    tick();
    check("rst_enq_valid", 128'(bus.enq_valid), 128'd0);
    check("rst_enq_data",  128'(bus.enq_data),  128'd0);
    check("rst_grant_id",  128'(bus.grant_id),  128'd0);
    check("rst_credits",   128'(bus.credit_count), 128'd8);
    check("rst_overflow",  128'(bus.credit_overflow), 128'd0);
    check("rst_req_ready", 128'(bus.req_ready), 128'd0);
    rst = 1'b0;

    // Round-robin with a credit returned alongside every grant
    bus.credit_return = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_req_ready", 128'(bus.req_ready), 128'(4'b0001 << (k % NR)));
      check("rr_onehot", 128'($countones(bus.req_ready)), 128'd1);
      tick();
      check("rr_grant_id",  128'(bus.grant_id),  128'(k % NR));
      check("rr_enq_data",  128'(bus.enq_data),  128'(pkt(k % NR)));
      check("rr_enq_valid", 128'(bus.enq_valid), 128'd1);
      check("rr_credits",   128'(bus.credit_count), 128'd8);
    end
    bus.req_valid     = '0;
    bus.credit_return = 1'b0;
    tick();
    check("drain_enq_valid", 128'(bus.enq_valid), 128'd0);
    check("drain_grant_id",  128'(bus.grant_id),  128'd1);
    check("drain_enq_data",  128'(bus.enq_data),  128'(pkt(1)));

    // Credit exhaustion on requester 2
    bus.req_valid = 4'b0100;
    accepts = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.req_ready[2] && bus.req_valid[2]) accepts++;
      tick();
    end
    check("exh_accepts",  128'(accepts), 128'd8);
    check("exh_credits",  128'(bus.credit_count), 128'd0);
    check("exh_grant_id", 128'(bus.grant_id), 128'd2);
    bus.credit_return = 1'b1;
    #1;
    check("exh_no_grant_on_return", 128'(bus.req_ready), 128'd0);
    tick();
    bus.credit_return = 1'b0;
    check("exh_credit_back", 128'(bus.credit_count), 128'd1);
    #1;
    check("exh_regrant", 128'(bus.req_ready), 128'b0100);
    tick();
    check("exh_credits_again", 128'(bus.credit_count), 128'd0);
    #1;
    check("exh_blocked_again", 128'(bus.req_ready), 128'd0);

    // Simultaneous grant and return at count 5
    bus.req_valid     = '0;
    bus.credit_return = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("sim_pre_credits", 128'(bus.credit_count), 128'd5);
    bus.req_valid = 4'b0001;
    #1;
    check("sim_req_ready", 128'(bus.req_ready), 128'b0001);
    tick();
    check("sim_credits",  128'(bus.credit_count), 128'd5);
    check("sim_grant_id", 128'(bus.grant_id), 128'd0);
    bus.credit_return = 1'b0;

    // Backpressure with 0xA5 held in the output register
    lane_data[1]  = 128'hA5;
    load_lanes();
    bus.req_valid = 4'b0010;
    tick();
    check("bp_loaded", 128'(bus.enq_data), 128'hA5);
    check("bp_credits_loaded", 128'(bus.credit_count), 128'd4);
    bus.enq_ready = 1'b0;
    lane_data[1]  = 128'h5A;
    load_lanes();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_no_grant", 128'(bus.req_ready), 128'd0);
      tick();
      check("bp_enq_valid", 128'(bus.enq_valid), 128'd1);
      check("bp_enq_data",  128'(bus.enq_data),  128'hA5);
      check("bp_credits",   128'(bus.credit_count), 128'd4);
    end
    bus.enq_ready = 1'b1;
    #1;
    check("bp_release_grant", 128'(bus.req_ready), 128'b0010);
    tick();
    check("bp_new_data",    128'(bus.enq_data), 128'h5A);
    check("bp_credits_after", 128'(bus.credit_count), 128'd3);
    bus.req_valid = '0;
    lane_data[1]  = pkt(1);
    load_lanes();

    // Overflow: refill to 8, then one extra return
    bus.credit_return = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("ovf_full", 128'(bus.credit_count), 128'd8);
    check("ovf_clear", 128'(bus.credit_overflow), 128'd0);
    tick();
    bus.credit_return = 1'b0;
    check("ovf_saturate", 128'(bus.credit_count), 128'd8);
    check("ovf_set", 128'(bus.credit_overflow), 128'd1);
    tick();
    tick();
    check("ovf_sticky", 128'(bus.credit_overflow), 128'd1);

    // Mid-traffic reset (rr_ptr is at 2, so traffic lands on requester 2)
    bus.req_valid = 4'hF;
    tick();
    check("mr_pre_grant", 128'(bus.grant_id), 128'd2);
    check("mr_pre_valid", 128'(bus.enq_valid), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_enq_valid", 128'(bus.enq_valid), 128'd0);
    check("mr_enq_data",  128'(bus.enq_data),  128'd0);
    check("mr_grant_id",  128'(bus.grant_id),  128'd0);
    check("mr_credits",   128'(bus.credit_count), 128'd8);
    check("mr_overflow",  128'(bus.credit_overflow), 128'd0);
    check("mr_req_ready", 128'(bus.req_ready), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mr_first_grant", 128'(bus.req_ready), 128'b0001);
    tick();
    check("mr_first_id",   128'(bus.grant_id), 128'd0);
    check("mr_first_data", 128'(bus.enq_data), 128'(pkt(0)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
